// File: rtl/axis_pkt_fifo.sv
// Store-and-forward AXIS packet FIFO: a packet is released on m_axis only once its
// tlast beat is stored. Oversize packets (longer than DEPTH) fall back to cut-through.
// Ports:
//   s_axis_*       64-bit beat input (tdata, tlast, tvalid, tready)
//   m_axis_*       64-bit beat output, first-word-fall-through
//   fifo_level     beats stored, 0..DEPTH
//   pkt_pending    complete packets stored and not yet fully read
//   pkt_cnt        {tx_pkt_total, rx_pkt_total}, both 16-bit wrapping
module axis_pkt_fifo #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              s_axis_aclk,
  input  logic              s_axis_aresetn,
  input  logic [63:0]       s_axis_tdata,
  input  logic              s_axis_tlast,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  output logic [63:0]       m_axis_tdata,
  output logic              m_axis_tlast,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic [ADDR_W:0]   fifo_level,
  output logic [15:0]       pkt_pending,
  output logic [31:0]       pkt_cnt
);

  localparam logic [ADDR_W:0] FULL_LVL = DEPTH[ADDR_W:0];
  localparam logic [ADDR_W:0] PTR_ONE  = (ADDR_W+1)'(1);

  logic [64:0]     mem_q [DEPTH];
  logic [ADDR_W:0] wptr_q, wptr_d;
  logic [ADDR_W:0] rptr_q, rptr_d;
  logic [15:0]     pend_q, pend_d;
  logic [15:0]     rx_q, rx_d;
  logic [15:0]     tx_q, tx_d;
  logic            fwd_q, fwd_d;

  logic [ADDR_W:0] level;
  logic            full;
  logic            empty;
  logic            s_hsk;
  logic            m_hsk;
  logic            s_lst;
  logic            m_lst;

  assign level = wptr_q - rptr_q;
  assign full  = (level == FULL_LVL);
  assign empty = (level == '0);

  assign s_axis_tready = ~full;
  assign {m_axis_tlast, m_axis_tdata} = mem_q[rptr_q[ADDR_W-1:0]];
  assign m_axis_tvalid = ~empty & ((pend_q != '0) | fwd_q);

  assign s_hsk = s_axis_tvalid & s_axis_tready;
  assign m_hsk = m_axis_tvalid & m_axis_tready;
  assign s_lst = s_hsk & s_axis_tlast;
  assign m_lst = m_hsk & m_axis_tlast;

  assign fifo_level  = level;
  assign pkt_pending = pend_q;
  assign pkt_cnt     = {tx_q, rx_q};

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    pend_d = pend_q;
    rx_d   = rx_q;
    tx_d   = tx_q;
    fwd_d  = fwd_q;
    if (s_hsk) wptr_d = wptr_q + PTR_ONE;
    if (m_hsk) rptr_d = rptr_q + PTR_ONE;
    if (s_lst) rx_d = rx_q + 16'd1;
    if (m_lst) tx_d = tx_q + 16'd1;
    unique case ({s_lst, m_lst})
      2'b10:   pend_d = pend_q + 16'd1;
      2'b01:   pend_d = pend_q - 16'd1;
      default: pend_d = pend_q;
    endcase
    // Full with no complete packet: the packet can never finish
    // storing, so release it cut-through until its tlast leaves.
    if (full && (pend_q == '0)) fwd_d = 1'b1;
    if (m_lst) fwd_d = 1'b0;
  end

  always_ff @(posedge s_axis_aclk) begin
    if (!s_axis_aresetn) begin
      wptr_q <= '0;
      rptr_q <= '0;
      pend_q <= '0;
      rx_q   <= '0;
      tx_q   <= '0;
      fwd_q  <= 1'b0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      pend_q <= pend_d;
      rx_q   <= rx_d;
      tx_q   <= tx_d;
      fwd_q  <= fwd_d;
    end
  end

  // Storage is not reset; contents are don't-care while empty.
  always_ff @(posedge s_axis_aclk) begin
    if (s_hsk) mem_q[wptr_q[ADDR_W-1:0]] <= {s_axis_tlast, s_axis_tdata};
  end

endmodule

// File: tb/tb_axis_pkt_fifo.sv
// Bench for axis_pkt_fifo: directed packets, scoreboard of expected beats,
// separate monitor comparing every accepted output beat.
module tb_axis_pkt_fifo;

  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [63:0]       s_data = '0;
  logic              s_last = 1'b0;
  logic              s_valid = 1'b0;
  logic              s_ready;
  logic [63:0]       m_data;
  logic              m_last;
  logic              m_valid;
  logic              m_ready = 1'b0;
  logic [ADDR_W:0]   level;
  logic [15:0]       pending;
  logic [31:0]       pkt_cnt;

  int vecs = 0;
  int errs = 0;
  logic [64:0] sb[$];
  logic [64:0] exp_beat;
  logic        rnd_done;

  axis_pkt_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .s_axis_aclk   (clk),
    .s_axis_aresetn(rst_n),
    .s_axis_tdata  (s_data),
    .s_axis_tlast  (s_last),
    .s_axis_tvalid (s_valid),
    .s_axis_tready (s_ready),
    .m_axis_tdata  (m_data),
    .m_axis_tlast  (m_last),
    .m_axis_tvalid (m_valid),
    .m_axis_tready (m_ready),
    .fifo_level    (level),
    .pkt_pending   (pending),
    .pkt_cnt       (pkt_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [64:0] act,
                     input logic [64:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Monitor: a beat presented with valid & ready is accepted at the next edge.
  always @(negedge clk) begin
    if (rst_n && m_valid && m_ready) begin
      if (sb.size() == 0) begin
        vecs++;
        errs++;
        $display("FAIL unexpected_beat: got %0h want none", {m_last, m_data});
      end else begin
        exp_beat = sb.pop_front();
        chk("beat", {m_last, m_data}, exp_beat);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [63:0] d, input logic l);
    int t;
    t = 0;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    forever begin
      @(negedge clk);
      if (s_ready) begin
        sb.push_back({l, d});
        step();
        break;
      end
      step();
      t++;
      if (t > 300) begin
        chk("send_timeout", 65'(t), 65'd0);
        break;
      end
    end
    s_valid = 1'b0;
  endtask

  task automatic wait_level(input int lvl, input int lim);
    int t;
    t = 0;
    while (level != lvl[ADDR_W:0] && t < lim) begin
      step();
      t++;
    end
    chk("wait_level", 65'(level), 65'(lvl));
  endtask

  initial begin
    // Reset state
    repeat (2) step();
    chk("rst_m_valid", 65'(m_valid), 65'd0);
    chk("rst_s_ready", 65'(s_ready), 65'd1);
    chk("rst_level", 65'(level), 65'd0);
    chk("rst_pkt_cnt", 65'(pkt_cnt), 65'd0);
    chk("rst_pending", 65'(pending), 65'd0);
    rst_n = 1'b1;
    step();

    // 4-beat packet, held back until tlast stored, then 4 consecutive beats
    m_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send(64'hD000_0000_0000_0000 | 64'(i), i == 3);
      if (i < 3) chk("sf_hold", 65'(m_valid), 65'd0);
    end
    for (int k = 0; k < 4; k++) begin
      chk("sf_burst", 65'(m_valid), 65'd1);
      step();
    end
    chk("sf_done", 65'(m_valid), 65'd0);
    chk("sf_cnt", 65'(pkt_cnt), 65'h0001_0001);

    // 16 one-beat packets into a stalled output
    m_ready = 1'b0;
    for (int i = 0; i < 16; i++)
      send(64'h1600_0000_0000_0000 | 64'(i), 1'b1);
    chk("full_s_ready", 65'(s_ready), 65'd0);
    chk("full_level", 65'(level), 65'd16);
    chk("full_pending", 65'(pending), 65'd16);
    m_ready = 1'b1;
    wait_level(0, 100);
    chk("drain_pending", 65'(pending), 65'd0);
    chk("drain_cnt", 65'(pkt_cnt), 65'h0011_0011);

    // 20-beat oversize packet: fwd_mode after the FIFO fills
    m_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 20; i++)
          send(64'h2000_0000_0000_0000 | 64'(i), i == 19);
      end
      begin
        wait_level(16, 100);
        chk("ovr_held", 65'(m_valid), 65'd0);
        step();
        chk("ovr_fwd", 65'(m_valid), 65'd1);
        chk("ovr_pend", 65'(pending), 65'd0);
        m_ready = 1'b1;
      end
    join
    wait_level(0, 100);
    chk("ovr_cnt", 65'(pkt_cnt), 65'h0012_0012);

    // 40 packets of length 1..40, random valid gaps and ready
    rnd_done = 1'b0;
    fork
      begin
        for (int p = 0; p < 40; p++) begin
          int len;
          len = $urandom_range(1, 40);
          for (int i = 0; i < len; i++) begin
            if ($urandom_range(0, 1) == 0) step();
            send({16'h5A5A, 16'(p), 32'(i)}, i == len - 1);
          end
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          m_ready = ($urandom_range(0, 1) == 1);
          step();
        end
        m_ready = 1'b1;
      end
    join
    wait_level(0, 200);
    chk("rnd_cnt", 65'(pkt_cnt), 65'h003A_003A);

    // Reset with an incomplete 7-beat packet stored
    m_ready = 1'b0;
    for (int i = 0; i < 7; i++)
      send(64'h7000_0000_0000_0000 | 64'(i), 1'b0);
    chk("pre_rst_level", 65'(level), 65'd7);
    rst_n = 1'b0;
    sb.delete();
    step();
    chk("mid_rst_m_valid", 65'(m_valid), 65'd0);
    chk("mid_rst_level", 65'(level), 65'd0);
    chk("mid_rst_cnt", 65'(pkt_cnt), 65'd0);
    chk("mid_rst_s_ready", 65'(s_ready), 65'd1);
    rst_n = 1'b1;
    m_ready = 1'b1;
    send(64'hB0B0_0000_0000_0000, 1'b0);
    send(64'hB0B0_0000_0000_0001, 1'b1);
    wait_level(0, 20);
    chk("post_rst_cnt", 65'(pkt_cnt), 65'h0001_0001);

    // Counter wrap: 65535 one-beat packets, then one more
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 65535; i++)
      send({32'hC0DE_0000, 32'(i)}, 1'b1);
    repeat (3) step();
    chk("wrap_max", 65'(pkt_cnt), 65'hFFFF_FFFF);
    send(64'hEEEE_EEEE_EEEE_EEEE, 1'b1);
    repeat (3) step();
    chk("wrap_zero", 65'(pkt_cnt), 65'h0000_0000);
    chk("sb_empty", 65'(sb.size()), 65'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
